// File: rtl/ans_ht_ltf_receiver.sv
`default_nettype none
// ============================================================================
// Module   : ans_ht_ltf_receiver
// Captures one HT-LTF (cyclic prefix + body), scores the CP against the body
// tail and streams the body out over valid/ready.
// Revision : 1.0
// ============================================================================
module ans_ht_ltf_receiver #(
  parameter int SAMPLE_W = 32,
  parameter int CP_LEN   = 16,
  parameter int FFT_LEN  = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ltf_start,
  input  logic [SAMPLE_W-1:0]           sample_in,
  input  logic                          sample_valid,
  output logic [SAMPLE_W-1:0]           ht_ltf_out,
  output logic                          ht_ltf_out_valid,
  input  logic                          ht_ltf_out_ready,
  output logic                          ht_ltf_out_last,
  output logic                          ht_ltf_rx_busy,
  output logic                          ht_ltf_rx_done,
  output logic [$clog2(CP_LEN+1)-1:0]   cp_mismatch,
  output logic                          cp_ok
);

  localparam int c_IW = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1;
  localparam int c_CW = (CP_LEN > 1) ? $clog2(CP_LEN) : 1;
  localparam int c_MW = $clog2(CP_LEN + 1);
  localparam logic [c_IW-1:0] c_CP_LAST  = c_IW'(CP_LEN - 1);
  localparam logic [c_IW-1:0] c_FFT_LAST = c_IW'(FFT_LEN - 1);
  localparam logic [c_IW-1:0] c_TAIL     = c_IW'(FFT_LEN - CP_LEN);
  localparam logic [c_MW-1:0] c_MIS_MAX  = c_MW'(CP_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CP    = 2'd1,
    S_BODY  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [c_IW-1:0]       r_idx;
  logic [c_IW-1:0]       r_rd;
  logic [c_MW-1:0]       r_mismatch;
  logic                  r_cp_ok;
  logic                  r_done;
  logic [SAMPLE_W-1:0]   r_cp  [CP_LEN];
  logic [SAMPLE_W-1:0]   r_buf [FFT_LEN];

  logic                  w_start;
  logic                  w_xfer;
  logic                  w_tail_mis;
  logic [c_CW-1:0]       w_cp_wr;
  logic [c_CW-1:0]       w_cp_sel;

  // A start landing on the done cycle is refused so the next LTF begins one cycle later.
  assign w_start    = ltf_start && sample_valid && !r_done;
  assign w_xfer     = (r_state == S_DRAIN) && ht_ltf_out_ready;
  assign w_cp_wr    = c_CW'(r_idx);
  assign w_cp_sel   = c_CW'(r_idx - c_TAIL);
  assign w_tail_mis = (r_idx >= c_TAIL) && (sample_in != r_cp[w_cp_sel]);

  assign cp_mismatch    = r_mismatch;
  assign cp_ok          = r_cp_ok;
  assign ht_ltf_rx_done = r_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    ht_ltf_out       = '0;
    ht_ltf_out_valid = 1'b0;
    ht_ltf_out_last  = 1'b0;
    ht_ltf_rx_busy   = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = (CP_LEN == 1) ? S_BODY : S_CP;
        end
      end
      S_CP: begin
        if (sample_valid && (r_idx == c_CP_LAST)) begin
          w_state_nxt = S_BODY;
        end
      end
      S_BODY: begin
        if (sample_valid && (r_idx == c_FFT_LAST)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        ht_ltf_out_valid = 1'b1;
        ht_ltf_out       = r_buf[r_rd];
        ht_ltf_out_last  = (r_rd == c_FFT_LAST);
        if (w_xfer && (r_rd == c_FFT_LAST)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx      <= '0;
      r_rd       <= '0;
      r_mismatch <= '0;
      r_cp_ok    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_idx      <= (CP_LEN == 1) ? '0 : c_IW'(1);
            r_rd       <= '0;
            r_mismatch <= '0;
            r_cp_ok    <= 1'b0;
          end
        end
        S_CP: begin
          if (sample_valid) begin
            r_idx <= (r_idx == c_CP_LAST) ? '0 : r_idx + 1'b1;
          end
        end
        S_BODY: begin
          if (sample_valid) begin
            r_idx <= (r_idx == c_FFT_LAST) ? '0 : r_idx + 1'b1;
            if (w_tail_mis && (r_mismatch != c_MIS_MAX)) begin
              r_mismatch <= r_mismatch + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_xfer) begin
            if (r_rd == c_FFT_LAST) begin
              r_rd    <= '0;
              r_done  <= 1'b1;
              r_cp_ok <= (r_mismatch == '0);
            end else begin
              r_rd <= r_rd + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Sample storage carries no reset; an aborted capture is simply overwritten.
  always_ff @(posedge clk) begin
    if (!reset && sample_valid) begin
      if ((r_state == S_IDLE) && w_start) begin
        r_cp[0] <= sample_in;
      end
      if (r_state == S_CP) begin
        r_cp[w_cp_wr] <= sample_in;
      end
      if (r_state == S_BODY) begin
        r_buf[r_idx] <= sample_in;
      end
    end
  end

endmodule
`default_nettype wire
